// File: rtl/system_ir_tx_if.sv
// system_ir_tx_if: Avalon-MM slave bus bundle for the IR transmitter, including its level irq.
interface system_ir_tx_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/system_ir_tx.sv
// system_ir_tx: Avalon-MM NEC IR transmitter with carrier-modulated marks and a maskable done irq.
// Define IR_TX_REPEAT_EN to enable the STATUS bit3 NEC repeat-code trigger.
module system_ir_tx #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658
) (
    input  logic          clk,
    input  logic          reset_n,
    system_ir_tx_if.slave bus,
    output logic          out_port
);
    localparam int CW = $clog2(UNIT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LEADER_MARK, LEADER_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_SPACE} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cyc;
    logic [3:0]    r_unit;
    logic [4:0]    r_bit;
    logic [31:0]   r_frame;
    logic [15:0]   r_carrier, r_car_cnt;
    logic          r_done, r_ovr, r_mask, r_rep, r_out;
    logic          w_wr, w_wr_data, w_wr_stat, w_busy, w_start, w_rep_req, w_rep_start, w_unit_end, w_enter;

    function automatic logic is_mark(state_t s);
        return s == LEADER_MARK || s == BIT_MARK || s == STOP_MARK;
    endfunction

    // Unit count minus one, so the unit counter reaches zero on the state's last unit.
    function automatic logic [3:0] dur_m1(state_t s, logic b);
        return s == LEADER_MARK ? 4'd15 : s == LEADER_SPACE ? 4'd7 : s == REP_SPACE ? 4'd3 :
               (s == BIT_SPACE && b) ? 4'd2 : 4'd0;
    endfunction

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_wr_data  = w_wr && bus.address == 2'd0;
    assign w_wr_stat  = w_wr && bus.address == 2'd1;
    assign w_busy     = r_state != IDLE;
    assign w_start    = w_wr_data & ~w_busy;
`ifdef IR_TX_REPEAT_EN
    assign w_rep_req  = w_wr_stat & bus.writedata[3];
`else
    assign w_rep_req  = 1'b0;
`endif
    assign w_rep_start = w_rep_req & ~w_busy & ~w_start;
    assign w_unit_end  = w_busy && r_cyc == '0 && r_unit == '0;
    assign w_enter     = w_state_nxt != r_state;
    assign bus.irq     = r_done & r_mask;
    assign out_port    = r_out;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        if (!w_busy)
            w_state_nxt = (w_start || w_rep_start) ? LEADER_MARK : IDLE;
        else if (w_unit_end)
            case (r_state)
                LEADER_MARK:  w_state_nxt = r_rep ? REP_SPACE : LEADER_SPACE;
                LEADER_SPACE: w_state_nxt = BIT_MARK;
                BIT_MARK:     w_state_nxt = BIT_SPACE;
                BIT_SPACE:    w_state_nxt = r_bit == 5'd31 ? STOP_MARK : BIT_MARK;
                REP_SPACE:    w_state_nxt = STOP_MARK;
                default:      w_state_nxt = IDLE;
            endcase
    end

    // Every state entry reloads the timers and restarts the carrier in its high phase.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_cyc     <= '0;
            r_unit    <= '0;
            r_bit     <= '0;
            r_car_cnt <= '0;
            r_out     <= 1'b0;
        end else if (w_enter) begin
            r_cyc     <= CW'(UNIT_CYCLES - 1);
            r_unit    <= dur_m1(w_state_nxt, r_frame[r_bit]);
            r_car_cnt <= r_carrier - 16'd1;
            r_out     <= is_mark(w_state_nxt);
            if (!w_busy)
                r_bit <= '0;
            else if (r_state == BIT_SPACE)
                r_bit <= r_bit + 1'b1;
        end else begin
            r_cyc <= r_cyc == '0 ? CW'(UNIT_CYCLES - 1) : r_cyc - 1'b1;
            if (r_cyc == '0)
                r_unit <= r_unit - 1'b1;
            if (!is_mark(r_state))
                r_out <= 1'b0;
            else if (r_carrier == '0)
                r_out <= 1'b1;
            else if (r_car_cnt == '0) begin
                r_out     <= ~r_out;
                r_car_cnt <= r_carrier - 16'd1;
            end else
                r_car_cnt <= r_car_cnt - 16'd1;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_frame      <= '0;
            r_done       <= 1'b0;
            r_ovr        <= 1'b0;
            r_mask       <= 1'b0;
            r_rep        <= 1'b0;
            r_carrier    <= 16'(CARRIER_HALF);
            bus.readdata <= '0;
        end else begin
            if (w_start)
                r_frame <= bus.writedata;
            if (w_start || w_rep_start)
                r_rep <= w_rep_start;
            r_done <= (r_state == STOP_MARK && w_unit_end) || (r_done && !(w_wr_stat && bus.writedata[1]));
            r_ovr  <= ((w_wr_data || w_rep_req) && w_busy) || (r_ovr && !(w_wr_stat && bus.writedata[2]));
            if (w_wr && bus.address == 2'd2)
                r_mask <= bus.writedata[0];
            if (w_wr && bus.address == 2'd3)
                r_carrier <= bus.writedata[15:0];
            bus.readdata <= bus.address == 2'd0 ? r_frame :
                            bus.address == 2'd1 ? {29'd0, r_ovr, r_done, w_busy} :
                            bus.address == 2'd2 ? {31'd0, r_mask} : {16'd0, r_carrier};
        end
endmodule

// File: tb/tb_system_ir_tx.sv
// tb_system_ir_tx: randomized self-checking bench; expected out_port waveforms come from an NEC timing model.
module tb_system_ir_tx;
    localparam int U = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic out_port;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   exp_wave[$];

    system_ir_tx_if bus();
    system_ir_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port));

    always #5 clk = ~clk;

    function automatic void add_seg(input bit mark, input int units, input int h);
        for (int k = 0; k < units * U; k++)
            exp_wave.push_back(mark && (h == 0 || (k / h) % 2 == 0));
    endfunction

    function automatic void build(input bit rep, input logic [31:0] f, input int h);
        exp_wave.delete();
        add_seg(1, 16, h);
        if (rep)
            add_seg(0, 4, h);
        else begin
            add_seg(0, 8, h);
            for (int b = 0; b < 32; b++) begin
                add_seg(1, 1, h);
                add_seg(0, f[b] ? 3 : 1, h);
            end
        end
        add_seg(1, 1, h);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1; bus.write_n = 0; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 0; bus.write_n = 1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    // Starts a frame (or repeat code), optionally injects one write at sample inj_at, and checks the result.
    task automatic run_frame(input string name, input bit rep, input logic [31:0] f, input int h, input int inj_at,
                             input logic [1:0] inj_addr, input logic [31:0] inj_data, input logic [31:0] exp_status);
        int n, exp_busy, busy_cnt, wave_err, first_err;
        logic [31:0] last_rd;
        busy_cnt = 0; wave_err = 0; first_err = -1; last_rd = '0;
        bus_write(2'd3, 32'(h));
        bus_write(2'd1, 32'h6);
        build(rep, f, h);
        n = rep ? 21 * U : (89 + 2 * $countones(f)) * U;
        exp_busy = n - ((inj_at >= 0 && inj_addr == 2'd0) ? 1 : 0);
        @(negedge clk);
        bus.chipselect = 1; bus.write_n = 0;
        bus.address = rep ? 2'd1 : 2'd0;
        bus.writedata = rep ? 32'h8 : f;
        for (int i = 0; i <= n + 2; i++) begin
            @(negedge clk);
            if (out_port !== (i < exp_wave.size() ? exp_wave[i] : 1'b0)) begin
                wave_err++;
                if (first_err < 0) first_err = i;
            end
            if (inj_at >= 0 && i == inj_at + 1 && inj_addr == 2'd0) begin
                n_checks++;
                if (bus.readdata !== f) begin
                    n_fail++;
                    $display("FAIL %s data_readback: got %h expected %h", name, bus.readdata, f);
                end
            end else if (i >= 1 && bus.readdata[0] === 1'b1)
                busy_cnt++;
            last_rd = bus.readdata;
            bus.chipselect = 0; bus.write_n = 1; bus.address = 2'd1;
            if (i == inj_at) begin
                bus.chipselect = 1; bus.write_n = 0; bus.address = inj_addr; bus.writedata = inj_data;
            end
        end
        n_checks++;
        if (wave_err != 0) begin
            n_fail++;
            $display("FAIL %s waveform: %0d wrong cycles (first at %0d), expected 0", name, wave_err, first_err);
        end
        n_checks++;
        if (busy_cnt != exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        n_checks++;
        if (last_rd !== exp_status) begin
            n_fail++;
            $display("FAIL %s status_after: got %h expected %h", name, last_rd, exp_status);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_rd[4];
        exp_rd = '{32'd0, 32'd0, 32'd0, 32'd1};
        n_checks++;
        if (out_port !== 1'b0 || bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: out_port=%b irq=%b expected 0 0", out_port, bus.irq);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), d);
            n_checks++;
            if (d !== exp_rd[a]) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_rd[a]);
            end
        end
    endtask

    task automatic test_frames();
        run_frame("frame_zero", 0, 32'h0, 1, -1, 2'd1, 32'h0, 32'h2);
        run_frame("frame_ffff", 0, 32'h0000FFFF, 1, -1, 2'd1, 32'h0, 32'h2);
        for (int k = 0; k < 3; k++)
            run_frame($sformatf("frame_rand%0d", k), 0, $urandom, int'($urandom_range(0, 3)), -1, 2'd1, 32'h0, 32'h2);
        run_frame("carrier_off", 0, $urandom, 0, -1, 2'd1, 32'h0, 32'h2);
    endtask

    task automatic test_irq();
        logic [31:0] d, f;
        int n;
        bus_write(2'd2, 32'h1);
        run_frame("irq_frame", 0, $urandom, 1, -1, 2'd1, 32'h0, 32'h2);
        n_checks++;
        if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_on_done: got %b expected 1", bus.irq); end
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL w1c_zero: got %h expected 00000002", d); end
        bus_write(2'd1, 32'h2);
        n_checks++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", bus.irq); end
        f = $urandom;
        n = (89 + 2 * $countones(f)) * U;
        run_frame("done_clear_race", 0, f, 1, n - 1, 2'd1, 32'h2, 32'h2);
        n_checks++;
        if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_race: got %b expected 1", bus.irq); end
        bus_write(2'd2, 32'h0);
        n_checks++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", bus.irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] d, f;
        f = $urandom;
        run_frame("overrun", 0, f, 1, 100, 2'd0, 32'hFFFFFFFF, 32'h6);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== f) begin n_fail++; $display("FAIL overrun_data: got %h expected %h", d, f); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, $urandom);
        repeat (10) @(negedge clk);
        n_checks++;
        if (out_port !== 1'b1) begin n_fail++; $display("FAIL mid_mark_level: got %b expected 1", out_port); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_port !== 1'b0) begin n_fail++; $display("FAIL reset_abort_out: got %b expected 0", out_port); end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_abort_status: got %h expected 00000000", d); end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL reset_abort_carrier: got %h expected 00000001", d); end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_abort_data: got %h expected 00000000", d); end
    endtask

`ifdef IR_TX_REPEAT_EN
    task automatic test_repeat();
        run_frame("repeat_code", 1, 32'h0, 1, -1, 2'd1, 32'h0, 32'h2);
    endtask
`else
    task automatic test_repeat();
        logic [31:0] d;
        int highs;
        highs = 0;
        bus_write(2'd1, 32'h8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_port !== 1'b0) highs++;
        end
        n_checks++;
        if (highs != 0) begin n_fail++; $display("FAIL repeat_ignored_out: got %0d high cycles expected 0", highs); end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL repeat_ignored_status: got %h expected 00000000", d); end
    endtask
`endif

    initial begin
        bus.chipselect = 0; bus.write_n = 1; bus.address = 2'd0; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_frames();
        test_irq();
        test_overrun();
        test_reset_mid();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
